fpu_bf16_arbiter: RTL
=====================

Name: fpu_bf16_arbiter

Overview:
Shares the single bfloat16 FPU datapath between two requesters: r0, the core issue port, and r1, the Wishbone/UART-programmed test port. Each request is accepted through a valid/ready handshake and sequenced onto the FPU with a one-cycle start pulse. The block then waits for completion, or a timeout, and returns the result to the owning requester. The latest result is mirrored on a 16-bit status output that feeds the user IO pins [23:8].

Parameters:
DATA_W, 16, operand/result width (bfloat16)
OP_W, 5, FPU opcode width
FLAG_W, 5, exception flag width (NV, DZ, OF, UF, NX)
TIMEOUT, 64, max WAIT cycles before aborting an operation (>=2)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous reset, active-high
r0_req_valid / r1_req_valid  in  1  request valid
r0_req_ready / r1_req_ready  out  1  request accepted this cycle
r0_op / r1_op  in  OP_W  opcode
r0_a, r0_b / r1_a, r1_b  in  DATA_W  operands
r0_rsp_valid / r1_rsp_valid  out  1  response valid
r0_rsp_ready / r1_rsp_ready  in  1  response consumed
r0_rsp_data / r1_rsp_data  out  DATA_W  result
r0_rsp_flags / r1_rsp_flags  out  FLAG_W  exception flags
r0_rsp_err / r1_rsp_err  out  1  timeout abort
fpu_start_o  out  1  one-cycle start pulse
fpu_op_o  out  OP_W  opcode to FPU
fpu_a_o, fpu_b_o  out  DATA_W  operands to FPU
fpu_done_i  in  1  FPU completion pulse
fpu_result_i  in  DATA_W  FPU result
fpu_flags_i  in  FLAG_W  FPU flags
busy_o  out  1  state != IDLE
last_result_o  out  DATA_W  last completed result (IO mirror)
last_owner_o  out  1  requester served last

Behaviour:
- Reset: state IDLE. All outputs 0. Operand/op/result registers 0. last_owner_o=1, so r0 wins the first tie.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Exactly one operation is in flight.
- IDLE grant, combinational:
  - Only one requester valid: grant it.
  - Both valid: grant !last_owner_o.
  - req_ready is high only for the granted requester and only in IDLE.
- IDLE accept, on valid&ready: register op/a/b and owner; last_owner_o <= owner; go to ISSUE.
- ISSUE: fpu_start_o=1 for exactly one cycle. Clear timer. Go to WAIT.
- WAIT:
  - fpu_op_o/a_o/b_o stay driven from the registers, held stable through ISSUE and WAIT.
  - On fpu_done_i: capture result/flags; last_result_o <= fpu_result_i; err=0; go to RESP.
  - Otherwise increment timer. At timer==TIMEOUT-1 with no done: data=0, flags=0, err=1, last_result_o unchanged; go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - The owner's rsp_valid is high; data/flags/err stay stable until rsp_ready.
  - The non-owner's rsp_valid stays 0.
  - On handshake go to IDLE.
  - rsp_valid never drops without a handshake.
- Latency:
  - Accept at cycle T; start at T+1.
  - FPU latency L>=1: done at T+1+L, rsp_valid at T+2+L.
  - Timeout: rsp_valid at T+2+TIMEOUT.
  - Next accept at earliest the cycle after the response handshake.
- fpu_done_i is ignored in IDLE, ISSUE and RESP (stale or late completions are dropped).
- Reset mid-operation, any state: next cycle everything is at reset values and the pending op is discarded. Start is not reissued. A late done is ignored.
- Request signals of a non-granted requester may change freely; they are only sampled on handshake.

Decomposition:
- Package fpu_bf16_pkg holds:
  - opcode localparams: FADD, FSUB, FMUL, FMIN, FMAX, FEQ, FLT, FLE, FCLASS, FSGNJ, I2F, F2I, FMV;
  - flag bit indices;
  - state enum {IDLE, ISSUE, WAIT, RESP}.
- One sub-module is natural: rr_arb2, a two-way round-robin grant from (valid0, valid1, last_owner).

Test Plan:
1. r0 FADD a=0x3F80 b=0x4000, stub latency 3, accepted at T.
   -> fpu_start_o high only at T+1 with a/b driven.
   -> r0_rsp_data=0x4040, flags=0, err=0, rsp_valid at T+5.
   -> last_result_o=0x4040, last_owner_o=0.
2. Same cycle: r0 FMUL 0x4000*0x4040 and r1 FSUB 0x4040-0x3F80.
   -> r0 served first (0x40C0), then r1 (0x4000).
   -> A third simultaneous pair is granted to r0.
3. r1 op completes while r1_rsp_ready is held low for 10 cycles and r0_req_valid is high.
   -> r1 rsp_valid and data are stable for all 10 cycles; r0_req_ready stays 0.
   -> r0 is accepted the cycle after the r1 handshake.
4. Stub never asserts done, TIMEOUT=64, accepted at T.
   -> rsp_err=1, data=0x0000, rsp_valid at T+66; last_result_o unchanged.
5. Done asserted on the timer==TIMEOUT-1 cycle.
   -> err=0, result delivered.
6. wb_rst_i pulsed during WAIT, then a late fpu_done_i.
   -> Outputs 0, busy_o=0, no rsp_valid.
   -> A following r1 FADD 0x3F80+0x3F80 returns 0x4000 normally.

Source files
------------

// File: rtl/fpu_bf16_pkg.sv
// rtl/fpu_bf16_pkg.sv - shared opcodes, flag indices and FSM state for the bf16 FPU arbiter
package fpu_bf16_pkg;

  localparam logic [4:0] FADD   = 5'd0;
  localparam logic [4:0] FSUB   = 5'd1;
  localparam logic [4:0] FMUL   = 5'd2;
  localparam logic [4:0] FMIN   = 5'd3;
  localparam logic [4:0] FMAX   = 5'd4;
  localparam logic [4:0] FEQ    = 5'd5;
  localparam logic [4:0] FLT    = 5'd6;
  localparam logic [4:0] FLE    = 5'd7;
  localparam logic [4:0] FCLASS = 5'd8;
  localparam logic [4:0] FSGNJ  = 5'd9;
  localparam logic [4:0] I2F    = 5'd10;
  localparam logic [4:0] F2I    = 5'd11;
  localparam logic [4:0] FMV    = 5'd12;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; on a tie the requester not served last wins
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_owner,
  output logic grant0,
  output logic grant1
);

  assign grant0 = valid0 & (~valid1 | last_owner);
  assign grant1 = valid1 & (~valid0 | ~last_owner);

endmodule

// File: rtl/fpu_bf16_arbiter.sv
// rtl/fpu_bf16_arbiter.sv - shares one bf16 FPU between the core port (r0) and the test port (r1)
module fpu_bf16_arbiter #(
  parameter int DATA_W  = 16,
  parameter int OP_W    = 5,
  parameter int FLAG_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_rsp_data,
  output logic [FLAG_W-1:0] r0_rsp_flags,
  output logic              r0_rsp_err,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [OP_W-1:0]   r1_op,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_rsp_data,
  output logic [FLAG_W-1:0] r1_rsp_flags,
  output logic              r1_rsp_err,
  output logic              fpu_start_o,
  output logic [OP_W-1:0]   fpu_op_o,
  output logic [DATA_W-1:0] fpu_a_o,
  output logic [DATA_W-1:0] fpu_b_o,
  input  logic              fpu_done_i,
  input  logic [DATA_W-1:0] fpu_result_i,
  input  logic [FLAG_W-1:0] fpu_flags_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] last_result_o,
  output logic              last_owner_o
);

  import fpu_bf16_pkg::*;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t            state;
  logic [TW-1:0]     timer;
  logic              owner_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [FLAG_W-1:0] rsp_flags_q;
  logic              rsp_err_q;

  logic grant0;
  logic grant1;
  logic idle;
  logic rsp_ready_sel;

  rr_arb2 u_arb (
    .valid0     (r0_req_valid),
    .valid1     (r1_req_valid),
    .last_owner (last_owner_o),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  assign idle         = (state == IDLE);
  assign r0_req_ready = idle & grant0;
  assign r1_req_ready = idle & grant1;
  assign busy_o       = ~idle;

  assign fpu_op_o = op_q;
  assign fpu_a_o  = a_q;
  assign fpu_b_o  = b_q;

  // Response fields are only presented to the requester that owns the operation.
  assign r0_rsp_valid = rsp_valid_q & ~owner_q;
  assign r1_rsp_valid = rsp_valid_q & owner_q;
  assign r0_rsp_data  = owner_q ? '0 : rsp_data_q;
  assign r1_rsp_data  = owner_q ? rsp_data_q : '0;
  assign r0_rsp_flags = owner_q ? '0 : rsp_flags_q;
  assign r1_rsp_flags = owner_q ? rsp_flags_q : '0;
  assign r0_rsp_err   = rsp_err_q & ~owner_q;
  assign r1_rsp_err   = rsp_err_q & owner_q;
  assign rsp_ready_sel = owner_q ? r1_rsp_ready : r0_rsp_ready;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      timer         <= '0;
      owner_q       <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_flags_q   <= '0;
      rsp_err_q     <= 1'b0;
      fpu_start_o   <= 1'b0;
      last_result_o <= '0;
      last_owner_o  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            owner_q      <= grant1;
            last_owner_o <= grant1;
            op_q         <= grant1 ? r1_op : r0_op;
            a_q          <= grant1 ? r1_a : r0_a;
            b_q          <= grant1 ? r1_b : r0_b;
            fpu_start_o  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          fpu_start_o <= 1'b0;
          timer       <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          // A completion on the last timer cycle still counts as success.
          if (fpu_done_i) begin
            rsp_data_q    <= fpu_result_i;
            rsp_flags_q   <= fpu_flags_i;
            rsp_err_q     <= 1'b0;
            last_result_o <= fpu_result_i;
            rsp_valid_q   <= 1'b1;
            state         <= RESP;
          end else if (timer == TIMER_LAST) begin
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_sel) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
